// File: rtl/led_mean_tx.sv
// led_mean_tx: serialises the 8 per-zone RGB means to the LED backlight driver
// chain over a clock / data / latch link. Zone 0 first, R,G,B per zone, each
// channel MSB first. A start pulse that arrives while a frame is in flight is
// held in a single pending slot and sent after the current frame finishes.
// Build option: define LED_CRC_EN to append a CRC-8 (poly 0x07, init 0x00)
// over the data bits, sent MSB first after the last data bit.
module led_mean_tx #(
  parameter int ZONES     = 8,
  parameter int CH_W      = 4,
  parameter int CLK_DIV   = 4,
  parameter int LATCH_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ZONES*CH_W-1:0] MeanR,
  input  logic [ZONES*CH_W-1:0] MeanG,
  input  logic [ZONES*CH_W-1:0] MeanB,
  output logic                  led_sclk,
  output logic                  led_sdo,
  output logic                  led_latch,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o
);

  localparam int NB = ZONES * 3 * CH_W;
`ifdef LED_CRC_EN
  localparam int TB = NB + 8;
`else
  localparam int TB = NB;
`endif
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int LAT_W = $clog2(LATCH_CYC + 1);
  localparam int BIT_W = $clog2(TB + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t           state;
  logic [NB-1:0]    frame_in;   // inputs arranged in transmit order, first bit at MSB
  logic [NB-1:0]    load_frame;
  logic [NB-1:0]    sr;         // bits still to send after the one on led_sdo
  logic [NB-1:0]    pend;
  logic             pend_vld;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [LAT_W-1:0] lat_cnt;

  // Place zone z R,G,B channels in transmit order; no arithmetic, bit-exact.
  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    assign frame_in[NB-1-(3*z)*CH_W   -: CH_W] = MeanR[z*CH_W +: CH_W];
    assign frame_in[NB-1-(3*z+1)*CH_W -: CH_W] = MeanG[z*CH_W +: CH_W];
    assign frame_in[NB-1-(3*z+2)*CH_W -: CH_W] = MeanB[z*CH_W +: CH_W];
  end

  // A fresh start always wins over the pending slot when leaving IDLE.
  assign load_frame = start_i ? frame_in : pend;

`ifdef LED_CRC_EN
  logic [7:0] crc;       // running CRC during data, then the CRC shifter
  logic [7:0] crc_nxt;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ({8{c[7] ^ b}} & 8'h07);
  endfunction

  // CRC including the data bit currently on led_sdo.
  assign crc_nxt = crc_step(crc, led_sdo);
`endif

  // Frame sequencer, pending-slot capture and all registered outputs.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      led_sclk  <= 1'b0;
      led_sdo   <= 1'b0;
      led_latch <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      // NOTE: the data registers are cleared too, so nothing from an aborted
      // frame can leak into led_sdo later; the pending flag alone gates reuse.
      sr        <= '0;
      pend      <= '0;
      pend_vld  <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
`ifdef LED_CRC_EN
      crc       <= '0;
`endif
    end else begin
      done_o    <= 1'b0;
      overrun_o <= 1'b0;

      // While a frame is running (including the last LATCH cycle) a start
      // lands in the pending slot; a second one overwrites it.
      if (state != S_IDLE && start_i) begin
        pend     <= frame_in;
        pend_vld <= 1'b1;
        if (pend_vld) overrun_o <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_i || pend_vld) begin
            if (start_i && pend_vld) overrun_o <= 1'b1;
            pend_vld <= 1'b0;
            sr       <= {load_frame[NB-2:0], 1'b0};
            led_sdo  <= load_frame[NB-1];
            led_sclk <= 1'b0;
            busy_o   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
`ifdef LED_CRC_EN
            crc      <= '0;
`endif
            state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!led_sclk) begin
              led_sclk <= 1'b1;
            end else begin
              led_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                led_sdo   <= 1'b0;
                led_latch <= 1'b1;
                lat_cnt   <= '0;
                state     <= S_LATCH;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
`ifdef LED_CRC_EN
                if (bit_cnt < BIT_W'(NB - 1)) begin
                  led_sdo <= sr[NB-1];
                  sr      <= {sr[NB-2:0], 1'b0};
                  crc     <= crc_nxt;
                end else if (bit_cnt == BIT_W'(NB - 1)) begin
                  led_sdo <= crc_nxt[7];
                  crc     <= {crc_nxt[6:0], 1'b0};
                end else begin
                  led_sdo <= crc[7];
                  crc     <= {crc[6:0], 1'b0};
                end
`else
                led_sdo <= sr[NB-1];
                sr      <= {sr[NB-2:0], 1'b0};
`endif
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            led_latch <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mean_tx.sv
// tb_led_mean_tx: randomized and directed frames against a behavioural model
// that builds the expected bit stream from the zone means and computes the
// CRC byte-wise; a negedge monitor reassembles what the driver would capture.
module tb_led_mean_tx;

  localparam int NB = 96;
`ifdef LED_CRC_EN
  localparam int TB = NB + 8;
`else
  localparam int TB = NB;
`endif
  localparam int FLEN = 2 * 4 * TB + 4;   // SHIFT + LATCH cycles of one frame

  typedef logic [3:0] mean_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] MeanR = '0, MeanG = '0, MeanB = '0;
  logic        led_sclk, led_sdo, led_latch, busy_o, done_o, overrun_o;

  led_mean_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .MeanR    (MeanR),
    .MeanG    (MeanG),
    .MeanB    (MeanB),
    .led_sclk (led_sclk),
    .led_sdo  (led_sdo),
    .led_latch(led_latch),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int           cyc = 0;
  logic         sclk_q = 1'b0, busy_q = 1'b0;
  int           toggles = 0, nz_cnt = 0, latch_run = 0, nbits = 0;
  logic [127:0] cur = '0;
  logic [127:0] frm_q[$];
  int           frm_n[$], done_q[$], ovr_q[$], latch_q[$], rise_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cur   = '0;
      nbits = 0;
    end
    if (led_sclk !== sclk_q) toggles++;
    if (led_sclk === 1'b1 && sclk_q === 1'b0) begin
      cur = {cur[126:0], led_sdo};
      nbits++;
    end
    if ({led_sclk, led_sdo, led_latch, busy_o, done_o, overrun_o} !== 6'b0) nz_cnt++;
    if (led_latch === 1'b1) latch_run++;
    else if (latch_run > 0) begin
      latch_q.push_back(latch_run);
      latch_run = 0;
    end
    if (busy_o === 1'b1 && busy_q !== 1'b1) rise_q.push_back(cyc);
    if (done_o === 1'b1) begin
      frm_q.push_back(cur);
      frm_n.push_back(nbits);
      done_q.push_back(cyc);
      cur   = '0;
      nbits = 0;
    end
    if (overrun_o === 1'b1) ovr_q.push_back(cyc);
    sclk_q = led_sclk;
    busy_q = busy_o;
  end

  // ---------------- reference model ----------------
  mean_t mr[8], mg[8], mb[8];

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Expected bit stream, first transmitted bit at the highest used position.
  function automatic logic [127:0] model();
    logic [127:0] v = '0;
    logic [7:0]   crc = '0, acc = '0;
    int           n = 0;
    mean_t        m;
    for (int z = 0; z < 8; z++)
      for (int c = 0; c < 3; c++) begin
        m = (c == 0) ? mr[z] : (c == 1) ? mg[z] : mb[z];
        for (int b = 3; b >= 0; b--) begin
          v   = {v[126:0], m[b]};
          acc = {acc[6:0], m[b]};
          n++;
          if (n % 8 == 0) crc = crc8_byte(crc, acc);
        end
      end
`ifdef LED_CRC_EN
    v = {v[119:0], crc};
`endif
    return v;
  endfunction

  task automatic apply_means();
    for (int z = 0; z < 8; z++) begin
      MeanR[z*4 +: 4] = mr[z];
      MeanG[z*4 +: 4] = mg[z];
      MeanB[z*4 +: 4] = mb[z];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_at(input int c);
    goto(c);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Wait for the next completed frame and check bits, length, timing, latch.
  task automatic expect_frame(input string tag, input logic [127:0] exp_v,
                              input int load_c, output int done_c);
    int budget = 0;
    while (frm_q.size() == 0 && budget < 3 * FLEN) begin
      step();
      budget++;
    end
    done_c = cyc;
    if (frm_q.size() == 0) begin
      check({tag, " timeout"}, 0, 1);
      return;
    end
    done_c = done_q.pop_front();
    check({tag, " bits"}, frm_q.pop_front(), exp_v);
    check({tag, " nbits"}, frm_n.pop_front(), TB);
    check({tag, " done_cyc"}, done_c, load_c + FLEN + 1);
    check({tag, " busy_rise"}, (rise_q.size() > 0) ? rise_q.pop_front() : -1, load_c + 1);
    check({tag, " latch_len"}, (latch_q.size() > 0) ? latch_q.pop_front() : -1, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ea, eb, ec;
    int s, d1, d2, budget;

    // Reset, then 100 idle cycles with everything quiet.
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst sclk", led_sclk, 0);
    check("rst sdo", led_sdo, 0);
    check("rst latch", led_latch, 0);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst overrun", overrun_o, 0);
    toggles = 0;
    nz_cnt  = 0;
    repeat (100) step();
    check("idle toggles", toggles, 0);
    check("idle outputs", nz_cnt, 0);
    rise_q.delete();

    // Uniform 3/9/D pattern.
    for (int z = 0; z < 8; z++) begin mr[z] = 4'h3; mg[z] = 4'h9; mb[z] = 4'hD; end
    apply_means();
    ea = model();
    s = cyc + 2;
    pulse_at(s);
    expect_frame("pat39d", ea, s, d1);
    check("pat39d overrun", ovr_q.size(), 0);

    // Zone-unique means.
    for (int z = 0; z < 8; z++) begin
      mr[z] = mean_t'(z); mg[z] = ~mean_t'(z); mb[z] = mean_t'(z) ^ 4'hA;
    end
    apply_means();
    ea = model();
    s = cyc + 3;
    pulse_at(s);
    expect_frame("zones", ea, s, d1);

    // All-zero means (CRC byte 00 when the CRC is built in).
    for (int z = 0; z < 8; z++) begin mr[z] = '0; mg[z] = '0; mb[z] = '0; end
    apply_means();
    ea = model();
    s = cyc + 2;
    pulse_at(s);
    expect_frame("zero", ea, s, d1);

    // Random means.
    for (int t = 0; t < 3; t++) begin
      for (int z = 0; z < 8; z++) begin
        mr[z] = mean_t'($urandom_range(0, 15));
        mg[z] = mean_t'($urandom_range(0, 15));
        mb[z] = mean_t'($urandom_range(0, 15));
      end
      apply_means();
      ea = model();
      s = cyc + 1 + int'($urandom_range(0, 5));
      pulse_at(s);
      expect_frame($sformatf("rand%0d", t), ea, s, d1);
    end

    // Three starts in one frame: second is overwritten by the third.
    ovr_q.delete();
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means(); ea = model();
    s = cyc + 2;
    pulse_at(s);
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'(z); mb[z] = 4'h5; end
    apply_means();
    pulse_at(s + 100);
    for (int z = 0; z < 8; z++) begin mr[z] = 4'hF - mean_t'(z); mg[z] = mean_t'($urandom); mb[z] = 4'h6; end
    apply_means(); ec = model();
    pulse_at(s + 300);
    expect_frame("three f1", ea, s, d1);
    expect_frame("three f2", ec, d1, d2);
    check("three overrun count", ovr_q.size(), 1);
    check("three overrun cyc", (ovr_q.size() > 0) ? ovr_q[0] : -1, s + 301);

    // Start on the last LATCH cycle goes to pending, no overrun.
    ovr_q.delete();
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means(); ea = model();
    s = cyc + 2;
    pulse_at(s);
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means(); eb = model();
    pulse_at(s + FLEN);
    expect_frame("lastlatch f1", ea, s, d1);
    expect_frame("lastlatch f2", eb, d1, d2);
    check("lastlatch overrun", ovr_q.size(), 0);

    // Start in the done cycle with pending set: pending dropped, new data sent.
    ovr_q.delete();
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means(); ea = model();
    s = cyc + 2;
    pulse_at(s);
    for (int z = 0; z < 8; z++) begin mr[z] = 4'h1; mg[z] = 4'h2; mb[z] = 4'h4; end
    apply_means();
    pulse_at(s + 10);
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = 4'hC; mb[z] = mean_t'($urandom); end
    apply_means(); ec = model();
    pulse_at(s + FLEN + 1);
    expect_frame("idlepend f1", ea, s, d1);
    expect_frame("idlepend f2", ec, d1, d2);
    check("idlepend overrun count", ovr_q.size(), 1);
    check("idlepend overrun cyc", (ovr_q.size() > 0) ? ovr_q[0] : -1, s + FLEN + 2);
    repeat (FLEN + 50) step();
    check("idlepend no third frame", frm_q.size(), 0);

    // Reset mid-SHIFT at bit 40, then a full fresh frame.
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means();
    s = cyc + 2;
    pulse_at(s);
    budget = 0;
    while (nbits < 40 && budget < 2 * FLEN) begin step(); budget++; end
    check("abort reached bit 40", nbits, 40);
    rst = 1'b1;
    step();
    check("abort busy", busy_o, 0);
    check("abort sclk", led_sclk, 0);
    check("abort latch", led_latch, 0);
    check("abort done", done_o, 0);
    rst = 1'b0;
    repeat (FLEN + 100) step();
    check("abort no done", frm_q.size(), 0);
    rise_q.delete();
    latch_q.delete();
    for (int z = 0; z < 8; z++) begin mr[z] = mean_t'($urandom); mg[z] = mean_t'($urandom); mb[z] = mean_t'($urandom); end
    apply_means(); ea = model();
    s = cyc + 2;
    pulse_at(s);
    expect_frame("after abort", ea, s, d1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
